// File: rtl/motor_speed_ctrl.sv
// Motor speed controller: stop / manual pulse / semi-auto level / auto command modes,
// all driving a prescaled 1-LSB speed ramp toward a per-mode target.
module motor_speed_ctrl #(
    parameter int DATA_W       = 8,
    parameter int SPEED_W      = 4,
    parameter int NUM_LEVELS   = 7,
    parameter int LEVEL_STEP   = 30,
    parameter int PULSE_CYCLES = 1000,
    parameter int RAMP_DIV     = 4,
    parameter int TIMEOUT      = 2000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         rank,
    input  logic [3:0]         level,
    input  logic               control,
    input  logic [DATA_W-1:0]  rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               send_en,
    output logic [SPEED_W-1:0] speed,
    output logic               at_target,
    output logic               timeout
);

    typedef enum logic [1:0] {
        MODE_STOP   = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_SEMI   = 2'b10,
        MODE_AUTO   = 2'b11
    } mode_e;

    localparam int MAX_SPEED = (1 << SPEED_W) - 1;
    localparam int PRE_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int RUN_W     = $clog2(PULSE_CYCLES + 1);
    localparam int WD_W      = $clog2(TIMEOUT + 1);

    localparam logic [3:0]         TOP_LEVEL = 4'(NUM_LEVELS - 1);
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(RAMP_DIV - 1);
    localparam logic [RUN_W-1:0]   RUN_LOAD  = RUN_W'(PULSE_CYCLES);
    localparam logic [WD_W-1:0]    WD_MAX    = WD_W'(TIMEOUT);
    localparam logic [SPEED_W-1:0] SPEED_TOP = SPEED_W'(MAX_SPEED);

    function automatic logic [SPEED_W-1:0] level_to_target(input logic [3:0] lvl);
        int t;
        t = (int'(lvl) * MAX_SPEED) / (NUM_LEVELS - 1);
        return SPEED_W'(t);
    endfunction

    function automatic logic [3:0] sat_level(input logic [3:0] lvl);
        return (lvl > TOP_LEVEL) ? TOP_LEVEL : lvl;
    endfunction

    function automatic logic [3:0] decode_cmd(input logic [DATA_W-1:0] d);
        int q;
        if (d == '0) begin
            return 4'd0;
        end
        q = int'(d) / LEVEL_STEP + 1;
        if (q > NUM_LEVELS - 1) begin
            q = NUM_LEVELS - 1;
        end
        return 4'(q);
    endfunction

    mode_e              mode_q, mode_d;
    logic [3:0]         semi_level_q, semi_level_d;
    logic [3:0]         cmd_level_q, cmd_level_d;
    logic [2:0]         ctrl_sync_q, ctrl_sync_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               timeout_q, timeout_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [SPEED_W-1:0] target_last_q, target_last_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               at_target_q, at_target_d;

    mode_e              rank_mode;
    logic               accept;
    logic               ctrl_rise;
    logic [SPEED_W-1:0] target;

    assign rank_mode = mode_e'(rank);
    // Ready tracks the raw mode input so the very first auto cycle can already take a word.
    assign rx_ready  = rst && (rank_mode == MODE_AUTO);
    assign accept    = rx_valid && rx_ready;

    // NOTE: every variable gets a default at the top of the block so no path leaves it
    // unassigned -- that is what keeps this combinational process from inferring latches.
    always_comb begin
        mode_d        = rank_mode;
        semi_level_d  = sat_level(level);
        cmd_level_d   = accept ? decode_cmd(rx_data) : cmd_level_q;
        ctrl_sync_d   = {ctrl_sync_q[1:0], control};
        ctrl_rise     = ctrl_sync_q[1] && !ctrl_sync_q[2];
        run_d         = '0;
        wd_d          = '0;
        timeout_d     = 1'b0;
        target        = '0;
        pre_d         = pre_q;
        speed_d       = speed_q;

        if (mode_q == MODE_MANUAL) begin
            if (ctrl_rise) begin
                run_d = RUN_LOAD;
            end else if (run_q != '0) begin
                run_d = run_q - 1'b1;
            end
        end

        // Watchdog saturates at TIMEOUT so timeout stays asserted until a word arrives.
        if (mode_q == MODE_AUTO && !accept) begin
            wd_d      = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            timeout_d = (wd_d == WD_MAX);
        end

        unique case (mode_q)
            MODE_STOP:   target = '0;
            MODE_MANUAL: target = (run_q != '0) ? SPEED_TOP : '0;
            MODE_SEMI:   target = level_to_target(semi_level_q);
            MODE_AUTO:   target = timeout_q ? '0 : level_to_target(cmd_level_q);
            default:     target = '0;
        endcase
        target_last_d = target;

        if (target != target_last_q) begin
            pre_d = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (speed_q < target) begin
                speed_d = speed_q + 1'b1;
            end else if (speed_q > target) begin
                speed_d = speed_q - 1'b1;
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end

        // Stop acts on the raw mode input and bypasses the ramp entirely.
        if (rank_mode == MODE_STOP) begin
            speed_d = '0;
        end
        at_target_d = (speed_d == target);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q        <= MODE_STOP;
            semi_level_q  <= '0;
            cmd_level_q   <= '0;
            ctrl_sync_q   <= '0;
            run_q         <= '0;
            wd_q          <= '0;
            timeout_q     <= 1'b0;
            pre_q         <= '0;
            target_last_q <= '0;
            speed_q       <= '0;
            at_target_q   <= 1'b1;
        end else begin
            mode_q        <= mode_d;
            semi_level_q  <= semi_level_d;
            cmd_level_q   <= cmd_level_d;
            ctrl_sync_q   <= ctrl_sync_d;
            run_q         <= run_d;
            wd_q          <= wd_d;
            timeout_q     <= timeout_d;
            pre_q         <= pre_d;
            target_last_q <= target_last_d;
            speed_q       <= speed_d;
            at_target_q   <= at_target_d;
        end
    end

    assign send_en   = (mode_q == MODE_AUTO);
    assign speed     = speed_q;
    assign at_target = at_target_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Scoreboard bench for motor_speed_ctrl: expected values are queued as stimulus is
// applied and compared when the corresponding output is sampled on the falling edge.
module tb_motor_speed_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rank;
    logic [3:0] level;
    logic       control;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       send_en;
    logic [3:0] speed;
    logic       at_target;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    motor_speed_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rank      (rank),
        .level     (level),
        .control   (control),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .send_en   (send_en),
        .speed     (speed),
        .at_target (at_target),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input int v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input int got);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, got, -1);
        end else begin
            check(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] d, input int exp_speed, input int settle);
        rx_data  = d;
        rx_valid = 1'b1;
        sb_push(exp_speed);
        cyc(1);
        check("rx_ready_auto", int'(rx_ready), 1);
        rx_valid = 1'b0;
        cyc(settle);
        sb_check("auto_speed", int'(speed));
    endtask

    initial begin
        #500000;
        $display("FAIL sim_time_limit: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset with hostile inputs
        rst = 1'b0; rank = 2'b11; level = 4'd6; control = 1'b0;
        rx_data = 8'hFF; rx_valid = 1'b1;
        cyc(2);
        check("rst_speed", int'(speed), 0);
        check("rst_at_target", int'(at_target), 1);
        check("rst_timeout", int'(timeout), 0);
        check("rst_send_en", int'(send_en), 0);
        check("rst_rx_ready", int'(rx_ready), 0);

        // Semi-auto ramp 0 -> 15, one step every 4 cycles
        rst = 1'b1; rx_valid = 1'b0; rank = 2'b10; level = 4'd6;
        for (int i = 1; i <= 64; i++) sb_push((i < 2) ? 0 : (((i - 2) / 4 > 15) ? 15 : (i - 2) / 4));
        for (int i = 1; i <= 64; i++) begin
            cyc(1);
            sb_check("semi_ramp", int'(speed));
            if (i == 30) check("semi_at_target_mid", int'(at_target), 0);
        end
        check("semi_at_target_end", int'(at_target), 1);
        check("semi_send_en", int'(send_en), 0);

        // Mid-ramp level changes, including saturation of an out-of-range request
        level = 4'd2;  sb_push(5);  cyc(50); sb_check("semi_lvl2", int'(speed));
        level = 4'd15; sb_push(15); cyc(50); sb_check("semi_lvl_sat", int'(speed));
        level = 4'd5;  sb_push(12); cyc(20); sb_check("semi_lvl5", int'(speed));

        // Stop forces speed to 0 on the next edge
        rank = 2'b00;
        cyc(1);
        check("stop_speed", int'(speed), 0);

        // Words outside auto are not accepted
        rx_data = 8'hFF; rx_valid = 1'b1;
        cyc(1);
        check("rx_ready_stop", int'(rx_ready), 0);
        rx_valid = 1'b0; rank = 2'b11;
        cyc(1);
        check("send_en_auto", int'(send_en), 1);
        sb_push(0); cyc(70); sb_check("auto_ignored_word", int'(speed));

        // Auto command decode
        send_word(8'h1D, 2, 70);
        send_word(8'h1E, 5, 70);
        send_word(8'h96, 15, 70);
        send_word(8'hFF, 15, 70);

        // Watchdog
        rx_data = 8'h96; rx_valid = 1'b1;
        cyc(1);
        rx_valid = 1'b0;
        n = 0;
        while (!timeout && n < 2100) begin
            cyc(1);
            n++;
        end
        check("wd_cycles", n, 2000);
        sb_push(0); cyc(70); sb_check("wd_speed", int'(speed));
        rx_data = 8'h3C; rx_valid = 1'b1;
        cyc(1);
        check("wd_clear", int'(timeout), 0);
        rx_valid = 1'b0;
        sb_push(7); cyc(40); sb_check("wd_recover_speed", int'(speed));
        send_word(8'h00, 0, 40);

        // Manual: two pulses 500 cycles apart
        rank = 2'b01;
        cyc(3);
        sb_push(15); sb_push(15); sb_push(1); sb_push(0); sb_push(15); sb_push(14);
        control = 1'b1;
        for (int i = 1; i <= 1510; i++) begin
            cyc(1);
            if (i == 3 || i == 503) control = 1'b0;
            if (i == 500) control = 1'b1;
            if (i == 200)  sb_check("man_speed_200", int'(speed));
            if (i == 1100) sb_check("man_retrigger", int'(speed));
            if (i == 1503) sb_check("man_at_target_1503", int'(at_target));
            if (i == 1504) sb_check("man_at_target_1504", int'(at_target));
            if (i == 1507) sb_check("man_speed_1507", int'(speed));
            if (i == 1508) sb_check("man_speed_1508", int'(speed));
        end

        // Reset in the middle of an auto ramp
        rank = 2'b11; rx_data = 8'h1D; rx_valid = 1'b1;
        cyc(1);
        rx_valid = 1'b0;
        cyc(20);
        check("pre_rst_send_en", int'(send_en), 1);
        rst = 1'b0; rx_valid = 1'b1; rx_data = 8'hFF;
        cyc(1);
        check("mid_rst_speed", int'(speed), 0);
        check("mid_rst_at_target", int'(at_target), 1);
        check("mid_rst_timeout", int'(timeout), 0);
        check("mid_rst_send_en", int'(send_en), 0);
        check("mid_rst_rx_ready", int'(rx_ready), 0);
        rst = 1'b1; rx_valid = 1'b0;
        cyc(1);
        check("post_rst_send_en", int'(send_en), 1);
        sb_push(0); cyc(70); sb_check("post_rst_speed", int'(speed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
